bus_monitor: RTL and testbench

Synthesizable, parametrised observer on the core–memory bus.
- Passive tap: never drives the bus.
- Detects the halt address and enforces a cycle watchdog; reports completion with a cause code.
- Logs every access in a configurable MMIO window into an event FIFO. A bench, UART or debug port drains the FIFO over valid/ready.
- Replaces ad-hoc bench-side printing. Usable in simulation and on FPGA.

---
 rtl/bus_monitor_pkg.sv | 29 ++
 rtl/bus_monitor_if.sv | 26 ++
 rtl/bus_monitor_fifo.sv | 55 +++++
 rtl/bus_monitor.sv | 172 +++++++++++++++++
 tb/tb_bus_monitor.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_monitor_pkg.sv
// Shared types for the bus monitor: completion causes, FSM states, event record.
// Event record widths here match the default bus widths.
package bus_monitor_pkg;

    localparam int EVT_ADDR_W = 32;
    localparam int EVT_DATA_W = 32;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_HALT    = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } done_cause_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [EVT_ADDR_W-1:0] address;
        logic [EVT_DATA_W-1:0] data;
    } bus_evt_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_monitor_if.sv
// Core-memory bus tap plus event-drain handshake; master drives the bus and ready,
// slave (the monitor) only observes the bus and presents the event head.
interface bus_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] bus_address;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              evt_valid;
    logic              evt_ready;
    logic              evt_we;
    logic [ADDR_W-1:0] evt_address;
    logic [DATA_W-1:0] evt_data;

    modport master (
        output bus_address, bus_we, bus_wdata, bus_rdata, evt_ready,
        input  evt_valid, evt_we, evt_address, evt_data
    );

    modport slave (
        input  bus_address, bus_we, bus_wdata, bus_rdata, evt_ready,
        output evt_valid, evt_we, evt_address, evt_data
    );
endinterface

// File: rtl/bus_monitor_fifo.sv
// Synchronous FIFO with registered head: a push becomes visible the cycle after.
// Push is ignored when full unless a pop happens in the same cycle.
module evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CNT_FULL);
    assign do_pop     = pop_rdy_i && !empty_o;
    assign do_push    = push_vld_i && (!full_o || do_pop);
    assign head_dat_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/bus_monitor.sv
// Passive bus observer: halt/watchdog completion and MMIO access logging into a FIFO.
// Events appear on evt_* one cycle after capture; a full FIFO drops and counts events.
module bus_monitor
    import bus_monitor_pkg::*;
#(
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter logic [ADDR_W-1:0] MMIO_MASK    = 'h800,
    parameter logic [ADDR_W-1:0] MMIO_MATCH   = 'h800,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = 'hFFC,
    parameter int unsigned     TIMEOUT_CYCLES = 2000,
    parameter int              FIFO_DEPTH     = 8,
    parameter int              READ_LAT       = 0,
    parameter int              DEDUP          = 1
) (
    input  logic               clk,
    input  logic               resetn,
    bus_monitor_if.slave       bus,
    output logic               evt_overflow,
    output logic [7:0]         drop_count,
    output logic               done,
    output logic [1:0]         done_cause,
    output logic [31:0]        cycle_count
);
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } evt_t;

    state_e            state_q, state_d;
    done_cause_e       cause_q, cause_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              hist_vld_q, hist_vld_d;
    logic              hist_we_q, hist_we_d;
    logic [ADDR_W-1:0] hist_addr_q, hist_addr_d;
    logic [DATA_W-1:0] hist_wdata_q, hist_wdata_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              skid_vld_q, skid_vld_d;
    evt_t              skid_q, skid_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_q, drop_d;

    logic is_halt, is_mmio, is_dup, capture;
    logic push_vld, pop, drop;
    logic fifo_full, fifo_empty;
    evt_t cur_evt, push_dat, head;

    always_comb begin
        is_halt = (bus.bus_address == HALT_ADDR);
        is_mmio = ((bus.bus_address & MMIO_MASK) == MMIO_MATCH) && !is_halt;
        is_dup  = (DEDUP != 0) && hist_vld_q && (hist_we_q == bus.bus_we)
                  && (hist_addr_q == bus.bus_address) && (hist_wdata_q == bus.bus_wdata);
        capture = (state_q == ST_RUN) && is_mmio && !is_dup;
        cur_evt = '{we: bus.bus_we, address: bus.bus_address,
                    data: bus.bus_we ? bus.bus_wdata : bus.bus_rdata};

        state_d      = state_q;
        cause_d      = cause_q;
        cycle_d      = cycle_q;
        hist_vld_d   = is_mmio;
        hist_we_d    = bus.bus_we;
        hist_addr_d  = bus.bus_address;
        hist_wdata_d = bus.bus_wdata;
        pend_d       = 1'b0;
        pend_addr_d  = pend_addr_q;
        skid_vld_d   = skid_vld_q;
        skid_d       = skid_q;
        push_vld     = 1'b0;
        push_dat     = cur_evt;

        if (state_q == ST_RUN) begin
            cycle_d = cycle_q + 32'd1;
            if (is_halt) begin
                state_d = ST_DONE;
                cause_d = CAUSE_HALT;
            end else if ((TIMEOUT_CYCLES != 0) && (cycle_q == TIMEOUT_CYCLES - 1)) begin
                state_d = ST_DONE;
                cause_d = CAUSE_TIMEOUT;
            end
        end

        if (READ_LAT == 0) begin
            push_vld = capture;
        end else begin
            // Single FIFO write port: a late read outranks the skid, which outranks a new write.
            if (pend_q) begin
                push_vld = 1'b1;
                push_dat = '{we: 1'b0, address: pend_addr_q, data: bus.bus_rdata};
            end else if (skid_vld_q) begin
                push_vld   = 1'b1;
                push_dat   = skid_q;
                skid_vld_d = 1'b0;
            end
            if (capture && !bus.bus_we) begin
                pend_d      = 1'b1;
                pend_addr_d = bus.bus_address;
            end
            if (capture && bus.bus_we) begin
                if (push_vld) begin
                    skid_vld_d = 1'b1;
                    skid_d     = cur_evt;
                end else begin
                    push_vld = 1'b1;
                    push_dat = cur_evt;
                end
            end
        end

        pop    = !fifo_empty && bus.evt_ready;
        drop   = push_vld && fifo_full && !pop;
        ovf_d  = ovf_q | drop;
        drop_d = drop ? sat_inc8(drop_q) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_RUN;
            cause_q      <= CAUSE_NONE;
            cycle_q      <= '0;
            hist_vld_q   <= 1'b0;
            hist_we_q    <= 1'b0;
            hist_addr_q  <= '0;
            hist_wdata_q <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            skid_vld_q   <= 1'b0;
            skid_q       <= '0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            cycle_q      <= cycle_d;
            hist_vld_q   <= hist_vld_d;
            hist_we_q    <= hist_we_d;
            hist_addr_q  <= hist_addr_d;
            hist_wdata_q <= hist_wdata_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            skid_vld_q   <= skid_vld_d;
            skid_q       <= skid_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(evt_t))
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_vld_i (push_vld),
        .push_dat_i (push_dat),
        .pop_rdy_i  (bus.evt_ready),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.evt_valid   = !fifo_empty;
    assign bus.evt_we      = head.we;
    assign bus.evt_address = head.address;
    assign bus.evt_data    = head.data;
    assign evt_overflow    = ovf_q;
    assign drop_count      = drop_q;
    assign done            = (state_q == ST_DONE);
    assign done_cause      = cause_q;
    assign cycle_count     = cycle_q;
endmodule

// File: tb/tb_bus_monitor.sv
// Directed bench for bus_monitor: three instances share one stimulus
// (A: READ_LAT=0/DEDUP=1/TIMEOUT=100, B: DEDUP=0, C: READ_LAT=1).
module tb_bus_monitor;
    import bus_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] tb_addr = '0;
    logic        tb_we = 1'b0;
    logic [31:0] tb_wdata = '0;
    logic [31:0] tb_rdata = '0;
    logic        tb_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int pops_a = 0;
    int pops_b = 0;

    always #5 clk = ~clk;

    bus_monitor_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    bus_monitor_if #(.ADDR_W(32), .DATA_W(32)) if_b ();
    bus_monitor_if #(.ADDR_W(32), .DATA_W(32)) if_c ();

    assign if_a.bus_address = tb_addr;  assign if_b.bus_address = tb_addr;  assign if_c.bus_address = tb_addr;
    assign if_a.bus_we      = tb_we;    assign if_b.bus_we      = tb_we;    assign if_c.bus_we      = tb_we;
    assign if_a.bus_wdata   = tb_wdata; assign if_b.bus_wdata   = tb_wdata; assign if_c.bus_wdata   = tb_wdata;
    assign if_a.bus_rdata   = tb_rdata; assign if_b.bus_rdata   = tb_rdata; assign if_c.bus_rdata   = tb_rdata;
    assign if_a.evt_ready   = tb_ready; assign if_b.evt_ready   = tb_ready; assign if_c.evt_ready   = tb_ready;

    logic        ovf_a, ovf_b, ovf_c, done_a, done_b, done_c;
    logic [7:0]  drop_a, drop_b, drop_c;
    logic [1:0]  cause_a, cause_b, cause_c;
    logic [31:0] cyc_a, cyc_b, cyc_c;

    bus_monitor #(.TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .resetn(resetn), .bus(if_a), .evt_overflow(ovf_a), .drop_count(drop_a),
        .done(done_a), .done_cause(cause_a), .cycle_count(cyc_a));
    bus_monitor #(.DEDUP(0)) dut_b (
        .clk(clk), .resetn(resetn), .bus(if_b), .evt_overflow(ovf_b), .drop_count(drop_b),
        .done(done_b), .done_cause(cause_b), .cycle_count(cyc_b));
    bus_monitor #(.READ_LAT(1)) dut_c (
        .clk(clk), .resetn(resetn), .bus(if_c), .evt_overflow(ovf_c), .drop_count(drop_c),
        .done(done_c), .done_cause(cause_c), .cycle_count(cyc_c));

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (resetn && if_a.evt_valid && tb_ready) pops_a <= pops_a + 1;
        if (resetn && if_b.evt_valid && tb_ready) pops_b <= pops_b + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_evt(input string name, input logic vld, input bus_evt_t got, input bus_evt_t exp);
        check({name, "_vld"}, 128'(vld), 128'(1));
        check(name, 128'(got), 128'(exp));
    endtask

    function automatic bus_evt_t head_a();
        return {if_a.evt_we, if_a.evt_address, if_a.evt_data};
    endfunction

    function automatic bus_evt_t head_c();
        return {if_c.evt_we, if_c.evt_address, if_c.evt_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [31:0] rd);
        tb_addr = a; tb_we = w; tb_wdata = wd; tb_rdata = rd;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input logic ready);
        resetn = 1'b0;
        idle();
        tb_ready = ready;
        tick();
        tick();
        check("rst_a", 128'({ovf_a, drop_a, done_a, cause_a, cyc_a, if_a.evt_valid, if_a.evt_we,
                             if_a.evt_address, if_a.evt_data}), 128'(0));
        check("rst_b", 128'({ovf_b, drop_b, done_b, cause_b, cyc_b, if_b.evt_valid, if_b.evt_we,
                             if_b.evt_address, if_b.evt_data}), 128'(0));
        check("rst_c", 128'({ovf_c, drop_c, done_c, cause_c, cyc_c, if_c.evt_valid, if_c.evt_we,
                             if_c.evt_address, if_c.evt_data}), 128'(0));
        resetn = 1'b1;
    endtask

    initial begin
        int pa0, pb0;
        vecs[0] = '{32'h804,  1'b1, 32'h12345678, 32'h0,    1'b1, 32'h12345678};
        vecs[1] = '{32'h808,  1'b0, 32'h0,        32'hCAFE, 1'b1, 32'hCAFE};
        vecs[2] = '{32'h004,  1'b1, 32'hDEADBEEF, 32'h0,    1'b0, 32'h0};
        vecs[3] = '{32'h8FC,  1'b1, 32'hA5A5,     32'h1111, 1'b1, 32'hA5A5};
        vecs[4] = '{32'h800,  1'b0, 32'h0,        32'h11,   1'b1, 32'h11};
        vecs[5] = '{32'h1800, 1'b1, 32'h42,       32'h0,    1'b1, 32'h42};
        vecs[6] = '{32'h7FC,  1'b0, 32'h0,        32'h77,   1'b0, 32'h0};
        vecs[7] = '{32'hBFC,  1'b1, 32'h9,        32'h0,    1'b1, 32'h9};

        // Single accesses separated by idle cycles, drained immediately.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rdata);
            check($sformatf("tbl%0d_no_wt", i), 128'(if_a.evt_valid), 128'(0));
            tick();
            idle();
            if (vecs[i].exp_vld)
                check_evt($sformatf("tbl%0d", i), if_a.evt_valid, head_a(),
                          {vecs[i].we, vecs[i].addr, vecs[i].exp_data});
            else
                check($sformatf("tbl%0d_skip", i), 128'(if_a.evt_valid), 128'(0));
            tick();
        end
        check("tbl_ovf", 128'(ovf_a), 128'(0));

        // Halt at cycle 50.
        do_reset(1'b1);
        for (int i = 0; i < 50; i++) tick();
        check("halt_pre_cyc", 128'(cyc_a), 128'(50));
        drive(32'hFFC, 1'b1, 32'h1, 32'h0);
        tick();
        idle();
        check("halt_done", 128'({done_a, cause_a}), 128'({1'b1, 2'd1}));
        check("halt_cyc", 128'(cyc_a), 128'(51));
        check("halt_nolog", 128'(if_a.evt_valid), 128'(0));
        drive(32'h800, 1'b1, 32'h5, 32'h0);
        tick();
        idle();
        tick();
        check("done_frozen", 128'({done_a, cause_a, cyc_a}), 128'({1'b1, 2'd1, 32'd51}));
        check("done_nocap", 128'(if_a.evt_valid), 128'(0));

        // Watchdog at 100, then halt on the same final cycle.
        do_reset(1'b1);
        for (int i = 0; i < 99; i++) tick();
        check("to_pre", 128'({done_a, cyc_a}), 128'({1'b0, 32'd99}));
        tick();
        check("to_done", 128'({done_a, cause_a, cyc_a}), 128'({1'b1, 2'd2, 32'd100}));
        do_reset(1'b1);
        for (int i = 0; i < 99; i++) tick();
        drive(32'hFFC, 1'b0, 32'h0, 32'h0);
        tick();
        idle();
        check("to_halt_wins", 128'({done_a, cause_a, cyc_a}), 128'({1'b1, 2'd1, 32'd100}));

        // Overflow: ten writes into an 8-deep FIFO with no consumer.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(32'h800 + 32'(4 * i), 1'b1, 32'h100 + 32'(i), 32'h0);
            tick();
        end
        idle();
        check("ovf_drop", 128'({ovf_a, drop_a}), 128'({1'b1, 8'd2}));
        tick();
        check_evt("ovf_hold", if_a.evt_valid, head_a(), {1'b1, 32'h800, 32'h100});
        tb_ready = 1'b1;
        drive(32'h900, 1'b1, 32'h999, 32'h0);
        for (int k = 0; k < 8; k++) begin
            check_evt($sformatf("drain%0d", k), if_a.evt_valid, head_a(),
                      {1'b1, 32'h800 + 32'(4 * k), 32'h100 + 32'(k)});
            tick();
            idle();
        end
        check_evt("drain_fullpush", if_a.evt_valid, head_a(), {1'b1, 32'h900, 32'h999});
        tick();
        check("drain_empty", 128'({if_a.evt_valid, drop_a}), 128'({1'b0, 8'd2}));

        // Dedup: same write four times, a gap, then once more.
        do_reset(1'b1);
        pa0 = pops_a;
        pb0 = pops_b;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) idle();
            else drive(32'h800, 1'b1, 32'h55, 32'h0);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("dedup_on", 128'(pops_a - pa0), 128'(2));
        check("dedup_off", 128'(pops_b - pb0), 128'(5));

        // Late read followed by a write: read first, write from the skid next cycle.
        do_reset(1'b1);
        drive(32'h820, 1'b0, 32'h0, 32'h5);
        tick();
        drive(32'h824, 1'b1, 32'h77, 32'h99);
        check("rl1_no_early", 128'(if_c.evt_valid), 128'(0));
        tick();
        idle();
        check_evt("rl1_read", if_c.evt_valid, head_c(), {1'b0, 32'h820, 32'h99});
        tick();
        check_evt("rl1_skid", if_c.evt_valid, head_c(), {1'b1, 32'h824, 32'h77});
        tick();
        check("rl1_empty", 128'(if_c.evt_valid), 128'(0));

        // Late read whose data cycle is the halt cycle.
        do_reset(1'b1);
        drive(32'h810, 1'b0, 32'h0, 32'hDEAD);
        tick();
        drive(32'hFFC, 1'b0, 32'h0, 32'hBEEF);
        tick();
        idle();
        check_evt("rl1_halt_read", if_c.evt_valid, head_c(), {1'b0, 32'h810, 32'hBEEF});
        check("rl1_halt_done", 128'({done_c, cause_c}), 128'({1'b1, 2'd1}));
        tick();
        check("rl1_halt_only", 128'(if_c.evt_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
